// File: rtl/hash_stream_controller.sv
// hash_stream_controller: packs a byte stream into hash blocks and sequences init/next commands to a hash engine
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   din/din_valid/din_last/din_bytes/din_ready  message input stream (byte 0 = din[7:0])
//   abort                           discard the message in progress
//   busy, buf_empty, buf_full       status
//   init/next/final_block           one-cycle engine command, qualified by final_block
//   block, data_length              block data and cumulative byte count, held until the next command
//   hash_ready                      engine can take a command
//   digest/digest_valid             engine result
//   digest_out, hash_done           captured digest and its one-cycle update pulse
module hash_stream_controller #(
  parameter int BUS_WIDTH    = 64,
  parameter int BLOCK_WIDTH  = 1024,
  parameter int LEN_WIDTH    = 64,
  parameter int DIGEST_WIDTH = 512
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [BUS_WIDTH-1:0]             din,
  input  logic                             din_valid,
  input  logic                             din_last,
  input  logic [$clog2(BUS_WIDTH/8):0]     din_bytes,
  output logic                             din_ready,
  input  logic                             abort,
  output logic                             busy,
  output logic                             buf_empty,
  output logic                             buf_full,
  output logic                             init,
  output logic                             next,
  output logic                             final_block,
  output logic [BLOCK_WIDTH-1:0]           block,
  output logic [LEN_WIDTH-1:0]             data_length,
  input  logic                             hash_ready,
  input  logic [DIGEST_WIDTH-1:0]          digest,
  input  logic                             digest_valid,
  output logic [DIGEST_WIDTH-1:0]          digest_out,
  output logic                             hash_done
);
  localparam int PACKETS = BLOCK_WIDTH / BUS_WIDTH;
  localparam int BYTES   = BUS_WIDTH / 8;
  localparam int DBW     = $clog2(BYTES) + 1;
  localparam int IW      = $clog2(PACKETS + 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(PACKETS - 1);
  localparam logic [IW-1:0]  FULL_IDX  = IW'(PACKETS);
  localparam logic [DBW-1:0] WORD_BYTES = DBW'(BYTES);

  typedef enum logic [1:0] {FILL, ISSUE, HOLD, DIGEST} state_t;

  state_t                  state_q, state_d;
  logic [BLOCK_WIDTH-1:0]  buf_q, buf_d;
  logic [IW-1:0]           wr_idx_q, wr_idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic                    last_q, last_d;
  logic                    msg_first_q, msg_first_d;
  logic                    cmd_first_q, cmd_first_d;
  logic                    cmd_final_q, cmd_final_d;
  logic [BLOCK_WIDTH-1:0]  block_q, block_d;
  logic [LEN_WIDTH-1:0]    dlen_q, dlen_d;
  logic [DIGEST_WIDTH-1:0] digest_q, digest_d;
  logic                    hash_done_q, hash_done_d;
  logic                    busy_q, busy_d;
  logic [BUS_WIDTH-1:0]    word_m;
  logic [DBW-1:0]          add_bytes;
  logic                    accept, issue, capture;

  assign accept  = state_q == FILL && din_valid && !abort;
  assign issue   = state_q == ISSUE && hash_ready && !abort;
  assign capture = state_q == DIGEST && digest_valid && !abort;
  assign add_bytes = din_last ? din_bytes : WORD_BYTES;

  // bytes past din_bytes on a last beat are forced to zero
  always_comb begin
    for (int i = 0; i < BYTES; i++) word_m[8*i +: 8] = (!din_last || i < int'(din_bytes)) ? din[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && (din_last || wr_idx_q == LAST_IDX)) state_d = ISSUE;
      ISSUE:   if (hash_ready) state_d = HOLD;
      HOLD:    state_d = cmd_final_q ? DIGEST : FILL;
      DIGEST:  if (digest_valid) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (abort) state_d = FILL;
  end

  // the command is presented during the single HOLD cycle that follows the handshake
  always_comb begin
    din_ready   = state_q == FILL;
    init        = state_q == HOLD && cmd_first_q;
    next        = state_q == HOLD && !cmd_first_q;
    final_block = state_q == HOLD && cmd_final_q;
    buf_empty   = wr_idx_q == '0;
    buf_full    = wr_idx_q == FULL_IDX;
  end

  always_comb begin
    buf_d       = buf_q;
    wr_idx_d    = wr_idx_q;
    len_d       = len_q;
    last_d      = last_q;
    msg_first_d = msg_first_q;
    cmd_first_d = cmd_first_q;
    cmd_final_d = cmd_final_q;
    block_d     = block_q;
    dlen_d      = dlen_q;
    digest_d    = digest_q;
    hash_done_d = capture;
    busy_d      = accept ? 1'b1 : (hash_done_q ? 1'b0 : busy_q);
    if (accept) begin
      buf_d[int'(wr_idx_q)*BUS_WIDTH +: BUS_WIDTH] = word_m;
      wr_idx_d = wr_idx_q + IW'(1);
      len_d    = len_q + LEN_WIDTH'(add_bytes);
      last_d   = din_last;
    end
    if (issue) begin
      block_d     = buf_q;
      dlen_d      = len_q;
      buf_d       = '0;
      wr_idx_d    = '0;
      cmd_first_d = msg_first_q;
      cmd_final_d = last_q;
      msg_first_d = 1'b0;
      last_d      = 1'b0;
    end
    if (capture) begin
      digest_d    = digest;
      len_d       = '0;
      msg_first_d = 1'b1;
    end
    if (abort) begin
      buf_d       = '0;
      wr_idx_d    = '0;
      len_d       = '0;
      last_d      = 1'b0;
      msg_first_d = 1'b1;
      busy_d      = 1'b0;
      hash_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q       <= '0;
      wr_idx_q    <= '0;
      len_q       <= '0;
      last_q      <= 1'b0;
      msg_first_q <= 1'b1;
      cmd_first_q <= 1'b0;
      cmd_final_q <= 1'b0;
      block_q     <= '0;
      dlen_q      <= '0;
      digest_q    <= '0;
      hash_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      wr_idx_q    <= wr_idx_d;
      len_q       <= len_d;
      last_q      <= last_d;
      msg_first_q <= msg_first_d;
      cmd_first_q <= cmd_first_d;
      cmd_final_q <= cmd_final_d;
      block_q     <= block_d;
      dlen_q      <= dlen_d;
      digest_q    <= digest_d;
      hash_done_q <= hash_done_d;
      busy_q      <= busy_d;
    end
  end

  assign block       = block_q;
  assign data_length = dlen_q;
  assign digest_out  = digest_q;
  assign hash_done   = hash_done_q;
  assign busy        = busy_q;
endmodule
